// File: rtl/key_filter.sv
// Debounces an active-low push-button into a one-cycle press pulse and a debounced level; optional long-press pulse under KEY_LONG_PRESS_EN.
// Latency: key_flag asserts DEB_CNT+4 sclk cycles after a clean key_in falling edge (2 sync flops + history + filter).
// Backpressure: none; key_flag/key_long are fire-and-forget single-cycle pulses.
module key_filter #(
    parameter int DEB_CNT  = 999_999,
    parameter int LONG_CNT = 49_999_999
) (
    input  logic sclk,
    input  logic rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_state
`ifdef KEY_LONG_PRESS_EN
    ,
    output logic key_long
`endif
);

    localparam int MAX_CNT = (LONG_CNT > DEB_CNT) ? LONG_CNT : DEB_CNT;
    localparam int CW_RAW  = $clog2(MAX_CNT + 1);
    localparam int CW      = (CW_RAW < 20) ? 20 : CW_RAW;

    localparam logic [CW-1:0] DEB_TC = CW'(DEB_CNT);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          flag_nxt;

    logic sync1;
    logic sync2;
    logic hist;
    logic fall;
    logic rise;

    // Preset high so a released key looks idle straight out of reset.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign fall = hist & ~sync2;
    assign rise = ~hist & sync2;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + ONE;

    // Opposing edges are tested before terminal count so a bounce always restarts the filter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        flag_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (fall) begin
                    state_nxt = PRESS_FILT;
                end
            end
            PRESS_FILT: begin
                if (rise) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if ((cnt == DEB_TC) && !sync2) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                    flag_nxt  = 1'b1;
                end
            end
            DOWN: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = REL_FILT;
                end
            end
            REL_FILT: begin
                if (fall) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                end else if ((cnt == DEB_TC) && sync2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            key_flag  <= 1'b0;
            key_state <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_flag  <= flag_nxt;
            key_state <= (state_nxt == DOWN) || (state_nxt == REL_FILT);
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_TC  = CW'(LONG_CNT);
    localparam logic [CW-1:0] LONG_PRE = CW'(LONG_CNT - 1);

    logic [CW-1:0] long_cnt;

    // Counter only advances in DOWN and stops at LONG_TC, so the pulse fires once per press;
    // a release bounce through REL_FILT keeps the accumulated hold time.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            long_cnt <= '0;
            key_long <= 1'b0;
        end else begin
            key_long <= 1'b0;
            if (state == IDLE) begin
                long_cnt <= '0;
            end else if ((state == DOWN) && (long_cnt != LONG_TC)) begin
                long_cnt <= long_cnt + ONE;
                key_long <= (long_cnt == LONG_PRE);
            end
        end
    end
`endif

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: directed button scenarios plus random bounce, checked each cycle against a run-length reference.
module tb_key_filter;

    localparam int DEB = 9;
    localparam int LNG = 49;

    logic sclk   = 1'b0;
    logic rst    = 1'b1;
    logic key_in = 1'b1;
    logic key_flag;
    logic key_state;
`ifdef KEY_LONG_PRESS_EN
    logic key_long;
`endif

    key_filter #(.DEB_CNT(DEB), .LONG_CNT(LNG)) dut (
        .sclk      (sclk),
        .rst       (rst),
        .key_in    (key_in),
        .key_flag  (key_flag),
        .key_state (key_state)
`ifdef KEY_LONG_PRESS_EN
        ,
        .key_long  (key_long)
`endif
    );

    always #10 sclk = ~sclk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: the button is debounced when the synchronized level has opposed the
    // current debounced level for DEB+2 consecutive samples (fall sample + DEB+1 counts).
    logic m_mid, m_cur;
    int   m_run, m_held;
    logic m_down, e_flag, e_long;

    int cyc_n, n_flag, n_long, flag_at, long_at;

    task automatic model_reset();
        m_mid  = 1'b1;
        m_cur  = 1'b1;
        m_run  = 0;
        m_held = 0;
        m_down = 1'b0;
        e_flag = 1'b0;
        e_long = 1'b0;
    endtask

    task automatic model_step();
        e_flag = 1'b0;
        e_long = 1'b0;
        if (m_down && m_run == 0) begin
            m_held++;
            if (m_held == LNG) e_long = 1'b1;
        end
        if (m_cur == m_down) m_run++;
        else m_run = 0;
        if (m_run == DEB + 2) begin
            m_down = ~m_down;
            m_run  = 0;
            e_flag = m_down;
            if (!m_down) m_held = 0;
        end
        m_cur = m_mid;
        m_mid = key_in;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc_n, obs, exp);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock: update the reference on the rising edge, compare on the falling edge.
    task automatic cyc();
        @(posedge sclk);
        if (rst) model_reset();
        else model_step();
        @(negedge sclk);
        cyc_n++;
        chk("key_flag", key_flag, e_flag);
        chk("key_state", key_state, m_down);
        if (key_flag === 1'b1) begin
            n_flag++;
            flag_at = cyc_n;
        end
`ifdef KEY_LONG_PRESS_EN
        chk("key_long", key_long, e_long);
        if (key_long === 1'b1) begin
            n_long++;
            long_at = cyc_n;
        end
`endif
    endtask

    task automatic run(input logic lvl, input int n);
        key_in = lvl;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clear_stats();
        cyc_n   = 0;
        n_flag  = 0;
        n_long  = 0;
        flag_at = -1;
        long_at = -1;
    endtask

    initial begin
        model_reset();
        clear_stats();

        // Reset held 100 ns with key released.
        rst    = 1'b1;
        key_in = 1'b1;
        #100;
        @(negedge sclk);
        chk("rst_flag", key_flag, 1'b0);
        chk("rst_state", key_state, 1'b0);
`ifdef KEY_LONG_PRESS_EN
        chk("rst_long", key_long, 1'b0);
`endif
        rst = 1'b0;
        run(1'b1, 5);

        // Clean press held 30 cycles, then released.
        clear_stats();
        run(1'b0, 30);
        chk_int("press_flag_count", n_flag, 1);
        chk_int("press_flag_latency", flag_at, DEB + 4);
        chk("press_state_held", key_state, 1'b1);
        run(1'b1, DEB + 3);
        chk("release_state_still", key_state, 1'b1);
        run(1'b1, 2);
        chk("release_state_done", key_state, 1'b0);
        run(1'b1, 5);

        // Short bounces never qualify.
        clear_stats();
        for (int r = 0; r < 4; r++) begin
            run(1'b0, 5);
            run(1'b1, 8);
        end
        chk_int("glitch_flag_count", n_flag, 0);
        chk("glitch_state", key_state, 1'b0);

        // Release glitches while held down.
        clear_stats();
        run(1'b0, 20);
        for (int r = 0; r < 2; r++) begin
            run(1'b1, 3);
            run(1'b0, 8);
        end
        chk_int("down_glitch_flag_count", n_flag, 1);
        chk("down_glitch_state", key_state, 1'b1);
        run(1'b1, 20);
        chk("down_glitch_released", key_state, 1'b0);

        // Reset during the press filter aborts the press.
        clear_stats();
        run(1'b0, 6);
        rst    = 1'b1;
        key_in = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        run(1'b1, 15);
        chk_int("rst_abort_flag_count", n_flag, 0);
        chk("rst_abort_state", key_state, 1'b0);

        // Long hold: one press pulse, and with the option one long pulse LNG cycles later.
        clear_stats();
        run(1'b0, 80);
        chk_int("long_hold_flag_count", n_flag, 1);
`ifdef KEY_LONG_PRESS_EN
        chk_int("long_hold_long_count", n_long, 1);
        chk_int("long_hold_gap", long_at - flag_at, LNG);
`endif
        run(1'b1, 20);

        // Random bounce patterns against the reference.
        for (int s = 0; s < 250; s++) begin
            int len;
            logic lvl;
            lvl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(10, 70);
            else len = $urandom_range(1, 12);
            run(lvl, len);
        end
        run(1'b1, 20);
        chk("random_end_state", key_state, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
